chirp_dds: RTL and testbench
============================

// Module: chirp_dds
// PURPOSE
//  Linear-FM chirp generator for the radar transmit path. On chirp_init it sweeps
//  the DDS phase increment from freq_offset_in by tuning_word_coeff_in per sample
//  for chirp_count_max_in samples. I/Q (cos/sin) come from a pipelined CORDIC.
//  Status flags pace the waveform/ADC capture logic. Single-clock block.
// PARAMETERS
//  PHASE_W    32  phase accumulator / tuning word width
//  OUT_W      16  I/Q sample width, signed two's complement
//  CORDIC_N   16  CORDIC iterations (one pipeline stage each)
// PORTS
//  CLOCK                 in   1   sample clock; all logic on rising edge
//  RESET                 in   1   synchronous, active-high
//  IF_FREQ               in   28  tone tuning word (route 3'b001); inc = {IF_FREQ,4'b0}
//  DUC_DCC_ROUTE_CTRL    in   3   000 chirp, 001 IF tone, others: zero output
//  chirp_init            in   1   start request (level or pulse), sampled in IDLE
//  chirp_enable          in   1   global enable; low aborts or blocks a chirp
//  freq_offset_in        in   32  start phase increment
//  tuning_word_coeff_in  in   32  increment added to phase increment per sample
//  chirp_count_max_in    in   32  chirp length in samples (0 treated as 1)
//  IF_OUT_I              out  16  cosine sample
//  IF_OUT_Q              out  16  sine sample
//  IF_OUT_VALID          out  1   I/Q valid, aligned with samples
//  chirp_ready           out  1   high in IDLE (can accept chirp_init)
//  chirp_active          out  1   high while chirp phases are being issued
//  chirp_done            out  1   one-cycle pulse after last chirp phase
// BEHAVIOUR
//  Reset: all outputs 0 except chirp_ready=0 in the reset cycle and 1 in the next.
//   FSM=IDLE, phase=0, inc=0, count=0, pipeline valid bits cleared.
//  FSM IDLE: ready=1. chirp_init & chirp_enable & route==000 -> ACTIVE.
//   Latch phase=0, inc=freq_offset_in, coeff, max (0 -> 1), count=0.
//  ACTIVE: each cycle issue phase, then phase+=inc, inc+=coeff, count++.
//   All math is mod 2^32, no saturation.
//   Issued phase k is sum_{j<k}(off + j*coeff); sample 0 has phase 0.
//   After count==max-1 is issued -> DONE. chirp_init ignored while ACTIVE.
//   chirp_enable low in ACTIVE -> IDLE next cycle, no done pulse;
//   samples already in flight still drain.
//  DONE: chirp_done=1 for exactly 1 cycle, active=0, then IDLE.
//   Back-to-back: init in the first IDLE cycle restarts.
//  Inputs sampled only at chirp start; changes mid-chirp have no effect.
//  Route 001: free-running tone, phase+=IF_FREQ<<4 every cycle.
//   IF_OUT_VALID stays high after pipeline fill; FSM stays IDLE.
//  Route other: I=Q=0, VALID=0.
//  Route changes take effect immediately for newly issued phases.
//  CORDIC: rotation mode, CORDIC_N stages.
//   x0=19898 (32767/1.64676), y0=0, z0=phase[31:16].
//   Quadrant pre-rotation from phase[31:30] gives full-circle coverage.
//   atan table in 16-bit turn units; output register after last stage.
//  Latency: I/Q for phase issued in cycle t appears at t+CORDIC_N+2 (18 default).
//   IF_OUT_VALID is the issue-valid delayed by the same amount.
//  Accuracy: |I - 32767*cos|, |Q - 32767*sin| <= 8 LSB.
//  When VALID=0, I and Q are forced to 0.
// TESTING
//  1) Basic chirp: max=1024, off=768, coeff=1, pulse init.
//     -> active 1024 cycles, done pulse 1 cycle, ready returns.
//     -> VALID high 1024 cycles starting 18 cycles after the first issue.
//  2) Quarter-turn: off=32'h4000_0000, coeff=0, max=4.
//     -> (I,Q) ~ (32767,0),(0,32767),(-32767,0),(0,-32767), each within 8 LSB.
//  3) Sweep check: off=0, coeff=32'h0010_0000, max=16.
//     -> sample k phase = coeff*k*(k-1)/2; I/Q match cos/sin within 8 LSB.
//  4) Abort: drop chirp_enable 10 cycles into max=100 chirp.
//     -> no chirp_done pulse, exactly 10 valid samples, then IDLE.
//     -> init while ACTIVE is ignored.
//  5) Reset mid-chirp: RESET in cycle 50.
//     -> next cycle all outputs 0, no done pulse, VALID low; ready=1 afterwards.
//  6) Tone route 001, IF_FREQ=28'h100_0000 (inc 2^28).
//     -> VALID continuous, period-16 sinusoid; route 010 -> I=Q=0, VALID=0.

Source files
------------

// File: rtl/chirp_dds.sv
// Linear-FM chirp DDS: chirp/tone phase generation feeding a pipelined rotation-mode
// CORDIC that produces the I (cos) and Q (sin) sample streams.
module chirp_dds #(
   parameter int unsigned PHASE_W  = 32,
   parameter int unsigned OUT_W    = 16,
   parameter int unsigned CORDIC_N = 16
) (
   input  logic                     CLOCK,
   input  logic                     RESET,
   input  logic [PHASE_W-5:0]       IF_FREQ,
   input  logic [2:0]               DUC_DCC_ROUTE_CTRL,
   input  logic                     chirp_init,
   input  logic                     chirp_enable,
   input  logic [PHASE_W-1:0]       freq_offset_in,
   input  logic [PHASE_W-1:0]       tuning_word_coeff_in,
   input  logic [31:0]              chirp_count_max_in,
   output logic signed [OUT_W-1:0]  IF_OUT_I,
   output logic signed [OUT_W-1:0]  IF_OUT_Q,
   output logic                     IF_OUT_VALID,
   output logic                     chirp_ready,
   output logic                     chirp_active,
   output logic                     chirp_done
);

   localparam int unsigned ZW    = 16;          // CORDIC angle width, 2^16 = one turn
   localparam int unsigned GUARD = 4;           // extra fraction bits against truncation drift
   localparam int unsigned IW    = OUT_W + 2 + GUARD;

   localparam logic signed [IW-1:0] KPOS = IW'(19898 * (2 ** GUARD));
   localparam logic signed [IW-1:0] KNEG = -KPOS;
   localparam logic signed [IW-1:0] RND  = IW'(2 ** (GUARD - 1));
   localparam logic signed [IW-1:0] OMAX = IW'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [IW-1:0] OMIN = -OMAX;

   typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

   state_e             state_q;
   logic [PHASE_W-1:0] phase_q, inc_q, coeff_q, tone_q;
   logic [31:0]        max_q, count_q;
   logic               ready_q, active_q, done_q;

   logic               iss_vld;
   logic [ZW-1:0]      iss_z;

   logic [CORDIC_N:0]     vld_q;
   logic signed [IW-1:0]  x_q [CORDIC_N+1];
   logic signed [IW-1:0]  y_q [CORDIC_N+1];
   logic signed [ZW:0]    z_q [CORDIC_N];

   logic signed [OUT_W-1:0] i_q, q_q;
   logic                    ov_q;

   // atan(2^-i) in 1/65536-turn units
   function automatic logic signed [ZW:0] atan_lut(input int i);
      case (i)
         0:       return 17'sd8192;
         1:       return 17'sd4836;
         2:       return 17'sd2555;
         3:       return 17'sd1297;
         4:       return 17'sd651;
         5:       return 17'sd326;
         6:       return 17'sd163;
         7:       return 17'sd81;
         8:       return 17'sd41;
         9:       return 17'sd20;
         10:      return 17'sd10;
         11:      return 17'sd5;
         12:      return 17'sd3;
         13:      return 17'sd1;
         14:      return 17'sd1;
         default: return 17'sd0;
      endcase
   endfunction

   // Drop guard bits with rounding and clamp symmetrically to the output range
   function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [IW-1:0] v);
      logic signed [IW-1:0] r;
      r = (v + RND) >>> GUARD;
      if (r > OMAX)      return OMAX[OUT_W-1:0];
      else if (r < OMIN) return OMIN[OUT_W-1:0];
      else               return OUT_W'(r);
   endfunction

   // Chirp FSM: latches the sweep parameters at start and steps phase/increment per sample
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q  <= StIdle;
         phase_q  <= '0;
         inc_q    <= '0;
         coeff_q  <= '0;
         max_q    <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (chirp_init && chirp_enable && (DUC_DCC_ROUTE_CTRL == 3'b000)) begin
                  state_q  <= StActive;
                  phase_q  <= '0;
                  inc_q    <= freq_offset_in;
                  coeff_q  <= tuning_word_coeff_in;
                  max_q    <= (chirp_count_max_in == 32'd0) ? 32'd1 : chirp_count_max_in;
                  count_q  <= '0;
                  ready_q  <= 1'b0;
                  active_q <= 1'b1;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            StActive: begin
               if (!chirp_enable) begin
                  state_q  <= StIdle;
                  active_q <= 1'b0;
                  ready_q  <= 1'b1;
               end else begin
                  phase_q <= phase_q + inc_q;
                  inc_q   <= inc_q + coeff_q;
                  count_q <= count_q + 32'd1;
                  if (count_q == max_q - 32'd1) begin
                     state_q  <= StDone;
                     active_q <= 1'b0;
                     done_q   <= 1'b1;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Free-running IF tone accumulator, advances only while the tone route is selected
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         tone_q <= '0;
      end else if (DUC_DCC_ROUTE_CTRL == 3'b001) begin
         tone_q <= tone_q + {IF_FREQ, 4'b0000};
      end
   end

   // Route select: picks the phase source issued into the CORDIC this cycle
   always_comb begin
      iss_vld = 1'b0;
      iss_z   = phase_q[PHASE_W-1 -: ZW];
      case (DUC_DCC_ROUTE_CTRL)
         3'b000: iss_vld = (state_q == StActive) && chirp_enable;
         3'b001: begin
            iss_vld = 1'b1;
            iss_z   = tone_q[PHASE_W-1 -: ZW];
         end
         default: iss_vld = 1'b0;
      endcase
   end

   // CORDIC pipeline: quadrant pre-rotation, then one micro-rotation per stage
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         vld_q <= '0;
      end else begin
         vld_q <= {vld_q[CORDIC_N-1:0], iss_vld};
      end
      case (iss_z[ZW-1 -: 2])
         2'b00: begin x_q[0] <= KPOS; y_q[0] <= '0;   end
         2'b01: begin x_q[0] <= '0;   y_q[0] <= KPOS; end
         2'b10: begin x_q[0] <= KNEG; y_q[0] <= '0;   end
         default: begin x_q[0] <= '0; y_q[0] <= KNEG; end
      endcase
      // residual angle is in [0, quarter turn), inside CORDIC convergence range
      z_q[0] <= {3'b000, iss_z[ZW-3:0]};
      for (int i = 0; i < int'(CORDIC_N); i++) begin
         if (!z_q[i][ZW]) begin
            x_q[i+1] <= x_q[i] - (y_q[i] >>> i);
            y_q[i+1] <= y_q[i] + (x_q[i] >>> i);
         end else begin
            x_q[i+1] <= x_q[i] + (y_q[i] >>> i);
            y_q[i+1] <= y_q[i] - (x_q[i] >>> i);
         end
      end
      for (int i = 0; i < int'(CORDIC_N) - 1; i++) begin
         if (!z_q[i][ZW]) z_q[i+1] <= z_q[i] - atan_lut(i);
         else             z_q[i+1] <= z_q[i] + atan_lut(i);
      end
   end

   // Output register: samples forced to zero whenever not valid
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         i_q  <= '0;
         q_q  <= '0;
         ov_q <= 1'b0;
      end else begin
         ov_q <= vld_q[CORDIC_N];
         i_q  <= vld_q[CORDIC_N] ? round_sat(x_q[CORDIC_N]) : '0;
         q_q  <= vld_q[CORDIC_N] ? round_sat(y_q[CORDIC_N]) : '0;
      end
   end

   assign IF_OUT_I     = i_q;
   assign IF_OUT_Q     = q_q;
   assign IF_OUT_VALID = ov_q;
   assign chirp_ready  = ready_q;
   assign chirp_active = active_q;
   assign chirp_done   = done_q;

endmodule

// File: tb/tb_chirp_dds.sv
// Directed bench for chirp_dds: chirp timing, quarter-turn and sweep accuracy, abort,
// mid-chirp reset, IF tone route and zero route.
module tb_chirp_dds;

   logic               clk = 1'b0;
   logic               rst;
   logic [27:0]        if_freq;
   logic [2:0]         route;
   logic               init, enable;
   logic [31:0]        off, coeff, cmax;
   logic signed [15:0] out_i, out_q;
   logic               out_vld, ready, active, done;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int val_cnt, act_cnt, done_cnt, first_val, first_act;
   int cap_i[$];
   int cap_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   chirp_dds dut (
      .CLOCK                (clk),
      .RESET                (rst),
      .IF_FREQ              (if_freq),
      .DUC_DCC_ROUTE_CTRL   (route),
      .chirp_init           (init),
      .chirp_enable         (enable),
      .freq_offset_in       (off),
      .tuning_word_coeff_in (coeff),
      .chirp_count_max_in   (cmax),
      .IF_OUT_I             (out_i),
      .IF_OUT_Q             (out_q),
      .IF_OUT_VALID         (out_vld),
      .chirp_ready          (ready),
      .chirp_active         (active),
      .chirp_done           (done)
   );

   // Output monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (out_vld) begin
         cap_i.push_back(int'(out_i));
         cap_q.push_back(int'(out_q));
         val_cnt++;
         if (first_val < 0) first_val = cyc;
      end
      if (active) begin
         act_cnt++;
         if (first_act < 0) first_act = cyc;
      end
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input longint got, input longint exp,
                        input longint tol);
      longint d;
      checks++;
      d = got - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clr_mon();
      val_cnt = 0; act_cnt = 0; done_cnt = 0; first_val = -1; first_act = -1;
      cap_i.delete();
      cap_q.delete();
   endtask

   task automatic start_chirp(input logic [31:0] o, input logic [31:0] c,
                              input logic [31:0] m);
      off = o; coeff = c; cmax = m;
      clr_mon();
      init = 1'b1;
      tick();
      init = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         tick();
         n++;
      end
      check(tag, done_cnt, 1, 0);
   endtask

   function automatic int ecos(input longint ph);
      return int'(32767.0 * $cos(2.0 * 3.141592653589793 * real'(ph) / 4294967296.0));
   endfunction

   function automatic int esin(input longint ph);
      return int'(32767.0 * $sin(2.0 * 3.141592653589793 * real'(ph) / 4294967296.0));
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int qi [4] = '{32767, 0, -32767, 0};
      int qq [4] = '{0, 32767, 0, -32767};
      longint ph;
      rst = 1'b1; if_freq = '0; route = 3'b000; init = 1'b0; enable = 1'b1;
      off = '0; coeff = '0; cmax = '0;
      clr_mon();

      // Reset state
      tick();
      check("rst_ready", ready, 0, 0);
      check("rst_active", active, 0, 0);
      check("rst_valid", out_vld, 0, 0);
      check("rst_i", out_i, 0, 0);
      rst = 1'b0;
      tick();
      check("rst_ready_after", ready, 1, 0);

      // 1) Basic chirp
      start_chirp(32'd768, 32'd1, 32'd1024);
      check("t1_active_start", active, 1, 0);
      check("t1_ready_low", ready, 0, 0);
      wait_done(1100, "t1_done");
      tick();
      check("t1_ready_back", ready, 1, 0);
      check("t1_active_off", active, 0, 0);
      repeat (25) tick();
      check("t1_act_cycles", act_cnt, 1024, 0);
      check("t1_valid_cycles", val_cnt, 1024, 0);
      check("t1_latency", first_val - first_act, 18, 0);
      check("t1_done_pulses", done_cnt, 1, 0);
      check("t1_s0_i", cap_i[0], 32767, 8);
      check("t1_s0_q", cap_q[0], 0, 8);

      // 2) Quarter-turn steps
      start_chirp(32'h4000_0000, 32'd0, 32'd4);
      wait_done(20, "t2_done");
      repeat (25) tick();
      check("t2_count", cap_i.size(), 4, 0);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t2_i%0d", k), cap_i[k], qi[k], 8);
         check($sformatf("t2_q%0d", k), cap_q[k], qq[k], 8);
      end

      // 3) Quadratic phase sweep
      start_chirp(32'd0, 32'h0010_0000, 32'd16);
      wait_done(30, "t3_done");
      repeat (25) tick();
      check("t3_count", cap_i.size(), 16, 0);
      for (int k = 0; k < 16; k++) begin
         ph = (longint'(32'h0010_0000) * k * (k - 1) / 2) & 64'hFFFF_FFFF;
         check($sformatf("t3_i%0d", k), cap_i[k], ecos(ph), 8);
         check($sformatf("t3_q%0d", k), cap_q[k], esin(ph), 8);
      end

      // 4) Abort after 10 issued samples; init held while active must be ignored
      start_chirp(32'd1000, 32'd3, 32'd100);
      init = 1'b1;
      repeat (10) tick();
      enable = 1'b0;
      tick();
      check("t4_active_off", active, 0, 0);
      check("t4_ready", ready, 1, 0);
      init = 1'b0;
      enable = 1'b1;
      repeat (25) tick();
      check("t4_valid_cycles", val_cnt, 10, 0);
      check("t4_no_done", done_cnt, 0, 0);
      check("t4_idle_ready", ready, 1, 0);

      // 5) Reset in the middle of a chirp
      start_chirp(32'd0, 32'd1, 32'd100);
      repeat (49) tick();
      rst = 1'b1;
      tick();
      check("t5_i", out_i, 0, 0);
      check("t5_q", out_q, 0, 0);
      check("t5_valid", out_vld, 0, 0);
      check("t5_ready", ready, 0, 0);
      check("t5_active", active, 0, 0);
      check("t5_done", done, 0, 0);
      rst = 1'b0;
      clr_mon();
      tick();
      check("t5_ready_after", ready, 1, 0);
      repeat (25) tick();
      check("t5_no_valid", val_cnt, 0, 0);
      check("t5_no_done", done_cnt, 0, 0);

      // 6) IF tone route, then zero route
      if_freq = 28'h100_0000;
      clr_mon();
      route = 3'b001;
      repeat (30) tick();
      val_cnt = 0;
      repeat (32) tick();
      check("t6_valid_cont", val_cnt, 32, 0);
      check("t6_state_idle", ready, 1, 0);
      for (int k = 0; k < 16; k++) begin
         ph = (longint'(k) << 28) & 64'hFFFF_FFFF;
         check($sformatf("t6_i%0d", k), cap_i[k], ecos(ph), 8);
         check($sformatf("t6_q%0d", k), cap_q[k], esin(ph), 8);
      end
      for (int k = 0; k < 8; k++) begin
         check($sformatf("t6_period%0d", k), cap_i[k + 16], cap_i[k], 0);
      end
      route = 3'b010;
      repeat (20) tick();
      check("t6z_valid", out_vld, 0, 0);
      check("t6z_i", out_i, 0, 0);
      check("t6z_q", out_q, 0, 0);
      val_cnt = 0;
      repeat (10) tick();
      check("t6z_no_valid", val_cnt, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
